// File: rtl/node_adc_sar_pkg.sv
// Node voltage scale shared by all node models, plus sizing helpers for the
// successive-approximation node reader.
`ifndef NODE_SCALE_DEFS
`define NODE_SCALE_DEFS
`ifndef W
`define W 16
`endif
`ifndef HI
`define HI 8191
`endif
`ifndef LO
`define LO (-8192)
`endif
`define ADC_SPAN (`HI-`LO)
`endif

package node_adc_sar_pkg;

    localparam int ADC_W    = `W;
    localparam int ADC_HI   = `HI;
    localparam int ADC_LO   = `LO;
    localparam int ADC_SPAN = `ADC_SPAN;

    // Sign bit plus one guard bit over the worst-case (vh-LO)<<N magnitude.
    function automatic int cmp_width(input int n);
        return ADC_W + n + 2;
    endfunction

endpackage

// File: rtl/node_adc_cmp.sv
// Combinational trial comparator: trial*(HI-LO) <= (vh-LO)*2^N, evaluated
// exactly in a signed width wide enough that neither side can overflow.
module node_adc_cmp
    import node_adc_sar_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]            trial_i,
    input  logic signed [ADC_W-1:0] vh_i,
    output logic                    le_o
);

    localparam int CW = cmp_width(N);

    logic signed [CW-1:0] lhs;
    logic signed [CW-1:0] rhs;

    always_comb begin
        lhs  = CW'(trial_i) * CW'(ADC_SPAN);
        rhs  = (CW'(vh_i) - CW'(ADC_LO)) <<< N;
        le_o = (lhs <= rhs);
    end

endmodule

// File: rtl/node_adc_sar.sv
// Successive-approximation reader for a simulated signed node voltage, with
// optional 2^AVG_LOG2 oversampling and a truncating mean.
module node_adc_sar
    import node_adc_sar_pkg::*;
#(
    parameter int N        = 8,
    parameter int AVG_LOG2 = 0
) (
    input  logic                    eclk,
    input  logic                    erst_n,
    input  logic signed [ADC_W-1:0] v,
    input  logic                    start,
    output logic                    busy,
    output logic                    valid,
    output logic [N-1:0]            code,
    output logic                    oor
);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        ACCUM,
        DONE
    } state_e;

    localparam int AW   = N + AVG_LOG2;
    localparam int CNTW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int BW   = $clog2(N);

    localparam logic [CNTW-1:0]         CNT_LAST = CNTW'((1 << AVG_LOG2) - 1);
    localparam logic [BW-1:0]           B_TOP    = BW'(N - 1);
    localparam logic signed [ADC_W-1:0] LO_V     = ADC_W'(ADC_LO);
    localparam logic signed [ADC_W-1:0] HI_V     = ADC_W'(ADC_HI);

    state_e                  state_q,   state_d;
    logic signed [ADC_W-1:0] vh_q,      vh_d;
    logic [N-1:0]            t_q,       t_d;
    logic [BW-1:0]           b_q,       b_d;
    logic [AW-1:0]           acc_q,     acc_d;
    logic [CNTW-1:0]         cnt_q,     cnt_d;
    logic                    oor_acc_q, oor_acc_d;
    logic [N-1:0]            code_q,    code_d;
    logic                    oor_q,     oor_d;

    logic [N-1:0] trial;
    logic         keep;

    assign trial = t_q | (N'(1) << b_q);

    node_adc_cmp #(
        .N(N)
    ) u_cmp (
        .trial_i (trial),
        .vh_i    (vh_q),
        .le_o    (keep)
    );

    always_ff @(posedge eclk) begin
        if (!erst_n) begin
            state_q   <= IDLE;
            vh_q      <= '0;
            t_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            oor_acc_q <= 1'b0;
            code_q    <= '0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vh_q      <= vh_d;
            t_q       <= t_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            oor_acc_q <= oor_acc_d;
            code_q    <= code_d;
            oor_q     <= oor_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vh_d      = vh_q;
        t_d       = t_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        oor_acc_d = oor_acc_q;
        code_d    = code_q;
        oor_d     = oor_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SAMPLE;
                    acc_d     = '0;
                    cnt_d     = '0;
                    oor_acc_d = 1'b0;
                end
            end
            SAMPLE: begin
                vh_d      = v;
                oor_acc_d = oor_acc_q | (v < LO_V) | (v > HI_V);
                t_d       = '0;
                b_d       = B_TOP;
                state_d   = CONVERT;
            end
            CONVERT: begin
                if (keep) begin
                    t_d = trial;
                end
                if (b_q == '0) begin
                    state_d = ACCUM;
                end else begin
                    b_d = b_q - BW'(1);
                end
            end
            ACCUM: begin
                acc_d = acc_q + AW'(t_q);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = SAMPLE;
                end
            end
            DONE: begin
                code_d  = acc_q[AW-1:AVG_LOG2];
                oor_d   = oor_acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The result is shown during the DONE cycle itself so code/oor change
    // together with the valid pulse, then held from the registers.
    always_comb begin
        busy  = (state_q == SAMPLE) || (state_q == CONVERT) || (state_q == ACCUM);
        valid = (state_q == DONE);
        code  = valid ? acc_q[AW-1:AVG_LOG2] : code_q;
        oor   = valid ? oor_acc_q : oor_q;
    end

endmodule

// File: tb/tb_node_adc_sar.sv
// Self-checking bench for node_adc_sar: a single-sample instance (N=8) and a
// 4x averaging instance (N=8, AVG_LOG2=2), checked against an arithmetic model.
module tb_node_adc_sar;

    localparam int VW = node_adc_sar_pkg::ADC_W;

    logic                 eclk;
    logic                 erst_n;
    logic signed [VW-1:0] v0, v2;
    logic                 start0, start2;
    logic                 busy0, valid0, oor0;
    logic                 busy2, valid2, oor2;
    logic [7:0]           code0, code2;

    int ncmp = 0;
    int nerr = 0;

    node_adc_sar #(.N(8), .AVG_LOG2(0)) dut0 (
        .eclk(eclk), .erst_n(erst_n), .v(v0), .start(start0),
        .busy(busy0), .valid(valid0), .code(code0), .oor(oor0)
    );

    node_adc_sar #(.N(8), .AVG_LOG2(2)) dut2 (
        .eclk(eclk), .erst_n(erst_n), .v(v2), .start(start2),
        .busy(busy2), .valid(valid2), .code(code2), .oor(oor2)
    );

    initial eclk = 1'b0;
    always #5 eclk = ~eclk;

    // Reference: largest c in [0, 2^n-1] with c*(HI-LO) <= (v-LO)*2^n.
    function automatic int ref_code(input int vin, input int n);
        longint num;
        longint c;
        num = longint'(vin + 8192) * (longint'(1) << n);
        if (num < 0) return 0;
        c = num / 16383;
        if (c > longint'((1 << n) - 1)) c = longint'((1 << n) - 1);
        return int'(c);
    endfunction

    function automatic int ref_oor(input int vin);
        return ((vin < -8192) || (vin > 8191)) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One conversion on dut0; optionally re-pulses start at cycle rep.
    task automatic conv0(input int vin, input int rep, output int lat,
                         output int nbusy, output int c, output int o);
        @(posedge eclk); #1;
        v0 = 16'(vin);
        start0 = 1'b1;
        @(posedge eclk); #1;
        start0 = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!valid0 && lat < 200) begin
            if (busy0) nbusy++;
            @(posedge eclk); #1;
            lat++;
            start0 = (lat == rep) ? 1'b1 : 1'b0;
        end
        start0 = 1'b0;
        c = int'(code0);
        o = int'(oor0);
    endtask

    // One averaged result on dut2; v switches from va to vb at cycle sw.
    task automatic conv2(input int va, input int vb, input int sw,
                         output int lat, output int c, output int o);
        @(posedge eclk); #1;
        v2 = 16'(va);
        start2 = 1'b1;
        @(posedge eclk); #1;
        start2 = 1'b0;
        lat = 1;
        while (!valid2 && lat < 400) begin
            @(posedge eclk); #1;
            lat++;
            if (lat == sw) v2 = 16'(vb);
        end
        c = int'(code2);
        o = int'(oor2);
    endtask

    typedef struct {
        int v;
        int code;
        int oor;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int lat, nb, c, o, nv, t;
        int tv[3];
        tbl[0]  = '{-8192,   0, 0};
        tbl[1]  = '{    0, 128, 0};
        tbl[2]  = '{ 4000, 190, 0};
        tbl[3]  = '{ 8191, 255, 0};
        tbl[4]  = '{ 9000, 255, 1};
        tbl[5]  = '{-9000,   0, 1};
        tbl[6]  = '{  100, 129, 0};
        tbl[7]  = '{-8191,   0, 0};
        tbl[8]  = '{ 8190, 255, 0};
        tbl[9]  = '{   -1, 127, 0};
        tbl[10] = '{-32768,  0, 1};
        tbl[11] = '{32767, 255, 1};

        erst_n = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        v0 = '0;
        v2 = '0;
        repeat (3) @(posedge eclk);
        #1;
        chk("rst_busy0",  int'(busy0),  0);
        chk("rst_valid0", int'(valid0), 0);
        chk("rst_code0",  int'(code0),  0);
        chk("rst_oor0",   int'(oor0),   0);
        chk("rst_busy2",  int'(busy2),  0);
        chk("rst_code2",  int'(code2),  0);
        erst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            conv0(tbl[i].v, 0, lat, nb, c, o);
            chk($sformatf("tbl%0d_lat", i), lat, 11);
            chk($sformatf("tbl%0d_busy_cycles", i), nb, 10);
            chk($sformatf("tbl%0d_busy_at_valid", i), int'(busy0), 0);
            chk($sformatf("tbl%0d_code", i), c, tbl[i].code);
            chk($sformatf("tbl%0d_oor", i), o, tbl[i].oor);
        end

        // Averaging: constant input, then a mid-result input step.
        conv2(0, 0, 0, lat, c, o);
        chk("avg_lat", lat, 41);
        chk("avg_code_zero", c, 128);
        chk("avg_oor", o, 0);
        conv2(0, 4000, 15, lat, c, o);
        chk("avg_step_code", c, 159);

        // Start re-pulsed mid-conversion must not queue a second result.
        conv0(4000, 4, lat, nb, c, o);
        chk("repulse_lat", lat, 11);
        chk("repulse_code", c, 190);
        nv = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge eclk); #1;
            if (valid0) nv++;
        end
        chk("repulse_extra_valids", nv, 0);
        chk("repulse_code_held", int'(code0), 190);

        // Start held high: back-to-back results 12 cycles apart.
        @(posedge eclk); #1;
        v0 = '0;
        start0 = 1'b1;
        nv = 0;
        t = 0;
        while (nv < 3 && t < 100) begin
            @(posedge eclk); #1;
            t++;
            if (valid0) begin
                tv[nv] = t;
                nv++;
                chk($sformatf("held_code%0d", nv), int'(code0), 128);
            end
        end
        start0 = 1'b0;
        chk("held_nvalid", nv, 3);
        if (nv == 3) begin
            chk("held_first", tv[0], 11);
            chk("held_gap1", tv[1] - tv[0], 12);
            chk("held_gap2", tv[2] - tv[1], 12);
        end

        // Reset in the middle of a conversion discards it.
        @(posedge eclk); #1;
        v0 = -16'sd1;
        start0 = 1'b1;
        @(posedge eclk); #1;
        start0 = 1'b0;
        repeat (4) @(posedge eclk);
        #1;
        chk("midconv_busy", int'(busy0), 1);
        erst_n = 1'b0;
        @(posedge eclk); #1;
        chk("abort_busy",  int'(busy0),  0);
        chk("abort_valid", int'(valid0), 0);
        chk("abort_code",  int'(code0),  0);
        erst_n = 1'b1;
        conv0(0, 0, lat, nb, c, o);
        chk("after_abort_lat", lat, 11);
        chk("after_abort_code", c, 128);

        // Randomized single conversions against the model.
        for (int i = 0; i < 40; i++) begin
            int vin;
            if ($urandom_range(1) == 0) vin = int'($urandom_range(65535)) - 32768;
            else vin = int'($urandom_range(18000)) - 9000;
            conv0(vin, 0, lat, nb, c, o);
            chk($sformatf("rnd%0d_code(v=%0d)", i, vin), c, ref_code(vin, 8));
            chk($sformatf("rnd%0d_oor(v=%0d)", i, vin), o, ref_oor(vin));
        end

        // Randomized averaged results with a step after the second sample.
        for (int i = 0; i < 8; i++) begin
            int va, vb;
            va = int'($urandom_range(20000)) - 10000;
            vb = int'($urandom_range(20000)) - 10000;
            conv2(va, vb, 15, lat, c, o);
            chk($sformatf("ravg%0d_code(%0d,%0d)", i, va, vb), c,
                (2 * ref_code(va, 8) + 2 * ref_code(vb, 8)) / 4);
            chk($sformatf("ravg%0d_oor(%0d,%0d)", i, va, vb), o,
                ref_oor(va) | ref_oor(vb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
